// File: rtl/unidade_controle_multiciclo.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencer that drives the
// datapath enables and counts retired instructions.
module unidade_controle_multiciclo #(
    parameter int unsigned LARGURA_CONTADOR = 32
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [5:0]                  opcode,
    input  logic                        mem_pronto,
    input  logic                        zero,
    output logic [2:0]                  estado,
    output logic                        ir_escreve,
    output logic                        pc_escreve,
    output logic                        mem_le,
    output logic                        mem_escreve,
    output logic                        reg_escreve,
    output logic                        alu_imediato,
    output logic                        mem_para_reg,
    output logic                        jal,
    output logic                        jalr,
    output logic                        ilegal,
    output logic [LARGURA_CONTADOR-1:0] contador_instrucoes
);

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_HALT   = 3'd5;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_ADDI = 6'h01;
    localparam logic [5:0] OP_LW   = 6'h02;
    localparam logic [5:0] OP_SW   = 6'h03;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_J    = 6'h05;
    localparam logic [5:0] OP_JAL  = 6'h06;
    localparam logic [5:0] OP_JALR = 6'h07;
    localparam logic [5:0] OP_HALT = 6'h3F;

    logic [2:0]                  r_estado;
    logic [2:0]                  w_prox_estado;
    logic [5:0]                  r_op_reg;
    logic [LARGURA_CONTADOR-1:0] r_contador;
    logic                        w_op_valido;
    logic                        w_retira;

    assign w_op_valido = (opcode <= OP_JALR);

    always_comb begin
        w_prox_estado = r_estado;
        case (r_estado)
            ST_FETCH: begin
                if (mem_pronto) w_prox_estado = ST_DECODE;
            end
            ST_DECODE: begin
                if (w_op_valido)            w_prox_estado = ST_EXEC;
                else if (opcode == OP_HALT) w_prox_estado = ST_HALT;
                else                        w_prox_estado = ST_FETCH;
            end
            ST_EXEC: begin
                case (r_op_reg)
                    OP_LW, OP_SW: w_prox_estado = ST_MEM;
                    OP_BEQ, OP_J: w_prox_estado = ST_FETCH;
                    default:      w_prox_estado = ST_WB;
                endcase
            end
            ST_MEM: begin
                if (mem_pronto) w_prox_estado = (r_op_reg == OP_LW) ? ST_WB : ST_FETCH;
            end
            ST_WB:   w_prox_estado = ST_FETCH;
            ST_HALT: w_prox_estado = ST_HALT;
            default: w_prox_estado = ST_FETCH;
        endcase
    end

    // An instruction retires only when it returns to FETCH after executing.
    assign w_retira = (w_prox_estado == ST_FETCH) &&
                      ((r_estado == ST_EXEC) || (r_estado == ST_MEM) || (r_estado == ST_WB));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado   <= ST_FETCH;
            r_op_reg   <= OP_R;
            r_contador <= '0;
        end else begin
            r_estado <= w_prox_estado;
            if (r_estado == ST_DECODE) r_op_reg <= opcode;
            if (w_retira) r_contador <= r_contador + LARGURA_CONTADOR'(1);
        end
    end

    always_comb begin
        ir_escreve   = 1'b0;
        pc_escreve   = 1'b0;
        mem_le       = 1'b0;
        mem_escreve  = 1'b0;
        reg_escreve  = 1'b0;
        alu_imediato = 1'b0;
        mem_para_reg = 1'b0;
        jal          = 1'b0;
        jalr         = 1'b0;
        ilegal       = 1'b0;
        case (r_estado)
            ST_FETCH: begin
                // Reset holds the state in FETCH, so its requests must be gated.
                mem_le     = reset;
                ir_escreve = reset & mem_pronto;
                pc_escreve = reset & mem_pronto;
            end
            ST_DECODE: begin
                ilegal = !w_op_valido && (opcode != OP_HALT);
            end
            ST_EXEC: begin
                alu_imediato = (r_op_reg == OP_ADDI) || (r_op_reg == OP_LW) ||
                               (r_op_reg == OP_SW);
                if ((r_op_reg == OP_J) || (r_op_reg == OP_JAL) || (r_op_reg == OP_JALR))
                    pc_escreve = 1'b1;
                else if (r_op_reg == OP_BEQ)
                    pc_escreve = zero;
                jal  = (r_op_reg == OP_JAL);
                jalr = (r_op_reg == OP_JALR);
            end
            ST_MEM: begin
                mem_le      = (r_op_reg == OP_LW);
                mem_escreve = (r_op_reg == OP_SW);
            end
            ST_WB: begin
                reg_escreve  = 1'b1;
                mem_para_reg = (r_op_reg == OP_LW);
                jal          = (r_op_reg == OP_JAL);
                jalr         = (r_op_reg == OP_JALR);
            end
            default: ;
        endcase
    end

    assign estado              = r_estado;
    assign contador_instrucoes = r_contador;

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Table-driven bench for the multi-cycle control unit; per-cycle expectations
// go through a scoreboard queue and are compared mid-cycle.
module tb_unidade_controle_multiciclo;

    localparam int unsigned W = 32;

    localparam logic [2:0] F = 3'd0, D = 3'd1, X = 3'd2, M = 3'd3, B = 3'd4, H = 3'd5;

    // Enable vector: {ir, pc, mem_le, mem_escreve, reg_escreve, alu_imm, mem2reg, jal, jalr, ilegal}
    localparam logic [9:0] E_IR = 10'h200, E_PC = 10'h100, E_ML = 10'h080, E_MW = 10'h040;
    localparam logic [9:0] E_RW = 10'h020, E_AI = 10'h010, E_MR = 10'h008, E_JL = 10'h004;
    localparam logic [9:0] E_JR = 10'h002, E_IL = 10'h001, E_0 = 10'h000;
    localparam logic [9:0] E_F  = E_IR | E_PC | E_ML;

    logic         clock = 1'b0;
    logic         reset;
    logic [5:0]   opcode;
    logic         mem_pronto;
    logic         zero;
    logic [2:0]   estado;
    logic         ir_escreve, pc_escreve, mem_le, mem_escreve, reg_escreve;
    logic         alu_imediato, mem_para_reg, jal, jalr, ilegal;
    logic [W-1:0] contador_instrucoes;
    logic [9:0]   w_en;

    typedef struct {
        logic [5:0]   op;
        logic         pr;
        logic         z;
        logic [2:0]   st;
        logic [9:0]   en;
        logic [W-1:0] cnt;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clock = ~clock;

    unidade_controle_multiciclo #(.LARGURA_CONTADOR(W)) dut (
        .clock               (clock),
        .reset               (reset),
        .opcode              (opcode),
        .mem_pronto          (mem_pronto),
        .zero                (zero),
        .estado              (estado),
        .ir_escreve          (ir_escreve),
        .pc_escreve          (pc_escreve),
        .mem_le              (mem_le),
        .mem_escreve         (mem_escreve),
        .reg_escreve         (reg_escreve),
        .alu_imediato        (alu_imediato),
        .mem_para_reg        (mem_para_reg),
        .jal                 (jal),
        .jalr                (jalr),
        .ilegal              (ilegal),
        .contador_instrucoes (contador_instrucoes)
    );

    assign w_en = {ir_escreve, pc_escreve, mem_le, mem_escreve, reg_escreve,
                   alu_imediato, mem_para_reg, jal, jalr, ilegal};

    task automatic chk(input int id, input logic [2:0] st, input logic [9:0] en,
                       input logic [W-1:0] cnt);
        n_vec++;
        if (estado !== st || w_en !== en || contador_instrucoes !== cnt) begin
            n_err++;
            $display("FAIL vec%0d: got estado=%0d en=%b cnt=%0d, want estado=%0d en=%b cnt=%0d",
                     id, estado, w_en, contador_instrucoes, st, en, cnt);
        end
    endtask

    task automatic add(input logic [5:0] op, input logic pr, input logic z, input logic [2:0] st,
                       input logic [9:0] en, input logic [W-1:0] cnt);
        vec_t v;
        v.op = op; v.pr = pr; v.z = z; v.st = st; v.en = en; v.cnt = cnt;
        tbl.push_back(v);
    endtask

    // Drive one cycle, check it mid-cycle, end 1 time unit past the next edge.
    task automatic step(input vec_t v, input int id);
        vec_t e;
        opcode     = v.op;
        mem_pronto = v.pr;
        zero       = v.z;
        sb.push_back(v);
        @(negedge clock);
        e = sb.pop_front();
        chk(id, e.st, e.en, e.cnt);
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset      = 1'b0;
        opcode     = 6'h00;
        mem_pronto = 1'b1;
        zero       = 1'b0;
        @(posedge clock);
        #1;
        chk(0, F, E_0, 0);
        reset = 1'b1;

        // R-type
        add(6'h00, 1, 0, F, E_F, 0); add(6'h00, 1, 0, D, E_0, 0);
        add(6'h00, 1, 0, X, E_0, 0); add(6'h00, 1, 0, B, E_RW, 0);
        // LW with three MEM stall cycles
        add(6'h02, 1, 0, F, E_F, 1); add(6'h02, 1, 0, D, E_0, 1);
        add(6'h02, 1, 0, X, E_AI, 1);
        add(6'h02, 0, 0, M, E_ML, 1); add(6'h02, 0, 0, M, E_ML, 1);
        add(6'h02, 0, 0, M, E_ML, 1); add(6'h02, 1, 0, M, E_ML, 1);
        add(6'h02, 1, 0, B, E_RW | E_MR, 1);
        // JAL, JALR
        add(6'h06, 1, 0, F, E_F, 2); add(6'h06, 1, 0, D, E_0, 2);
        add(6'h06, 1, 0, X, E_PC | E_JL, 2); add(6'h06, 1, 0, B, E_RW | E_JL, 2);
        add(6'h07, 1, 0, F, E_F, 3); add(6'h07, 1, 0, D, E_0, 3);
        add(6'h07, 1, 0, X, E_PC | E_JR, 3); add(6'h07, 1, 0, B, E_RW | E_JR, 3);
        // BEQ not taken, then taken
        add(6'h04, 1, 0, F, E_F, 4); add(6'h04, 1, 0, D, E_0, 4); add(6'h04, 1, 0, X, E_0, 4);
        add(6'h04, 1, 1, F, E_F, 5); add(6'h04, 1, 1, D, E_0, 5); add(6'h04, 1, 1, X, E_PC, 5);
        // ADDI with mem_pronto low outside FETCH/MEM
        add(6'h01, 1, 0, F, E_F, 6); add(6'h01, 0, 0, D, E_0, 6);
        add(6'h01, 0, 0, X, E_AI, 6); add(6'h01, 0, 0, B, E_RW, 6);
        // SW with one FETCH stall
        add(6'h03, 0, 0, F, E_ML, 7); add(6'h03, 1, 0, F, E_F, 7); add(6'h03, 1, 0, D, E_0, 7);
        add(6'h03, 1, 0, X, E_AI, 7); add(6'h03, 1, 0, M, E_MW, 7);
        // J; opcode changes during EXEC must not matter
        add(6'h05, 1, 0, F, E_F, 8); add(6'h05, 1, 0, D, E_0, 8); add(6'h3F, 1, 1, X, E_PC, 8);
        // Illegal opcode
        add(6'h2A, 1, 0, F, E_F, 9); add(6'h2A, 1, 0, D, E_IL, 9);
        // R-type up to WB (reset is asserted there below)
        add(6'h00, 1, 0, F, E_F, 9); add(6'h00, 1, 0, D, E_0, 9); add(6'h00, 1, 0, X, E_0, 9);

        for (int i = 0; i < tbl.size(); i++) step(tbl[i], i + 1);

        // Now 1 unit into WB; pulse reset asynchronously between edges.
        opcode = 6'h00;
        #2;
        chk(100, B, E_RW, 9);
        reset = 1'b0;
        #1;
        chk(101, F, E_0, 0);
        mem_pronto = 1'b0;
        #3;
        reset = 1'b1;
        @(posedge clock);
        #1;
        begin
            vec_t v;
            v.op = 6'h00; v.pr = 0; v.z = 0; v.st = F; v.en = E_ML; v.cnt = 0; step(v, 102);
            v.pr = 1;     v.st = F; v.en = E_F;  step(v, 103);
            v.st = D;     v.en = E_0;  step(v, 104);
            v.st = X;     v.en = E_0;  step(v, 105);
            v.st = B;     v.en = E_RW; step(v, 106);
            // HALT is held with every enable low
            v.op = 6'h3F; v.st = F; v.en = E_F; v.cnt = 1; step(v, 107);
            v.st = D;     v.en = E_0;  step(v, 108);
            for (int k = 0; k < 20; k++) begin
                v.op = 6'(k); v.z = k[0]; v.st = H; v.en = E_0;
                step(v, 109 + k);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
